// File: rtl/pdp8_mem_seq_pkg.sv
// Shared types and constants for the pdp8_ram requester-side sequencer.
package pdp8_mem_seq_pkg;

    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned DATA_W  = 12;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = 15;

    // Sequencer states; 3-bit encoding shared with other memory sequencers.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_e;

    // One CPU/front-panel memory request as seen on the request port.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Counter load value for a phase lasting len cycles.
    function automatic logic [CNT_W-1:0] phase_load(input int unsigned len);
        return CNT_W'(len - 32'd1);
    endfunction

    // A phase length must fit the counter and last at least one cycle.
    function automatic logic phase_len_ok(input int unsigned len);
        return (len >= 32'd1) && (len <= CNT_MAX);
    endfunction

endpackage

// File: rtl/pdp8_mem_seq_dly_cnt.sv
// Phase delay counter: load at phase entry, count down to zero and hold there.
module pdp8_mem_seq_dly_cnt
    import pdp8_mem_seq_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_cnt;

    // Down-counter; a load always wins over the decrement.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/pdp8_mem_seq.sv
// Requester-side sequencer for the pdp8_ram async-SRAM port: one read or write
// per handshake, with address setup, access/write-pulse and hold phases.
module pdp8_mem_seq
    import pdp8_mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_SETUP = 1,
    parameter int unsigned RD_ACCESS  = 2,
    parameter int unsigned WE_PULSE   = 2,
    parameter int unsigned WR_HOLD    = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready_c,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_ram_rd,
    output logic              o_ram_wr
);

    // Phase lengths outside 1..15 cannot be represented by the phase counter.
    if (!phase_len_ok(ADDR_SETUP)) begin : g_bad_addr_setup
        $error("pdp8_mem_seq: ADDR_SETUP=%0d outside 1..15", ADDR_SETUP);
    end
    if (!phase_len_ok(RD_ACCESS)) begin : g_bad_rd_access
        $error("pdp8_mem_seq: RD_ACCESS=%0d outside 1..15", RD_ACCESS);
    end
    if (!phase_len_ok(WE_PULSE)) begin : g_bad_we_pulse
        $error("pdp8_mem_seq: WE_PULSE=%0d outside 1..15", WE_PULSE);
    end
    if (!phase_len_ok(WR_HOLD)) begin : g_bad_wr_hold
        $error("pdp8_mem_seq: WR_HOLD=%0d outside 1..15", WR_HOLD);
    end

    localparam logic [CNT_W-1:0] LD_SETUP = phase_load(ADDR_SETUP);
    localparam logic [CNT_W-1:0] LD_RD    = phase_load(RD_ACCESS);
    localparam logic [CNT_W-1:0] LD_WE    = phase_load(WE_PULSE);
    localparam logic [CNT_W-1:0] LD_HOLD  = phase_load(WR_HOLD);

    state_e            r_state;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_op_we;
    logic              r_ram_rd;
    logic              r_ram_wr;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;

    state_e            w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              w_we_nxt;
    logic              w_rd_nxt;
    logic              w_wr_nxt;
    logic              w_resp_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              w_cnt_zero;
    logic              w_accept;
    mem_req_t          w_req;

    assign w_req         = '{we: i_req_we, addr: i_req_addr, wdata: i_req_wdata};
    assign o_req_ready_c = (r_state == ST_IDLE) & ~i_reset;
    assign w_accept      = i_req_valid & o_req_ready_c;

    // One shared counter times every phase; it is reloaded on each state entry.
    pdp8_mem_seq_dly_cnt u_dly_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_zero_c   (w_cnt_zero)
    );

    // Next-state and next-output logic; every phase ends when the counter is zero.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_ram_addr;
        w_wdata_nxt = r_ram_wdata;
        w_we_nxt    = r_op_we;
        w_rd_nxt    = r_ram_rd;
        w_wr_nxt    = r_ram_wr;
        w_resp_nxt  = 1'b0;
        w_rdata_nxt = r_resp_rdata;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;

        case (r_state)
            ST_IDLE: begin
                w_rd_nxt = 1'b0;
                w_wr_nxt = 1'b0;
                if (w_accept) begin
                    w_addr_nxt  = w_req.addr;
                    w_we_nxt    = w_req.we;
                    if (w_req.we) begin
                        w_wdata_nxt = w_req.wdata;
                    end
                    w_state_nxt = ST_SETUP;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = LD_SETUP;
                end
            end

            ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_cnt_load = 1'b1;
                    if (r_op_we) begin
                        w_state_nxt = ST_WR_PULSE;
                        w_wr_nxt    = 1'b1;
                        w_cnt_val   = LD_WE;
                    end else begin
                        w_state_nxt = ST_RD_WAIT;
                        w_rd_nxt    = 1'b1;
                        w_cnt_val   = LD_RD;
                    end
                end
            end

            ST_RD_WAIT: begin
                if (w_cnt_zero) begin
                    w_rdata_nxt = i_ram_rdata;
                    w_rd_nxt    = 1'b0;
                    w_resp_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_WR_PULSE: begin
                if (w_cnt_zero) begin
                    w_wr_nxt    = 1'b0;
                    w_state_nxt = ST_WR_HOLD;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = LD_HOLD;
                end
            end

            ST_WR_HOLD: begin
                if (w_cnt_zero) begin
                    w_resp_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_rd_nxt    = 1'b0;
                w_wr_nxt    = 1'b0;
            end
        endcase
    end

    // State register plus registered SRAM pins and response.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_op_we      <= 1'b0;
            r_ram_rd     <= 1'b0;
            r_ram_wr     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ram_addr   <= w_addr_nxt;
            r_ram_wdata  <= w_wdata_nxt;
            r_op_we      <= w_we_nxt;
            r_ram_rd     <= w_rd_nxt;
            r_ram_wr     <= w_wr_nxt;
            r_resp_valid <= w_resp_nxt;
            r_resp_rdata <= w_rdata_nxt;
        end
    end

    assign o_ram_addr   = r_ram_addr;
    assign o_ram_wdata  = r_ram_wdata;
    assign o_ram_rd     = r_ram_rd;
    assign o_ram_wr     = r_ram_wr;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;

endmodule
